uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among four byte requesters.
// Launches one byte at a time, waits for the frame to finish, then holds off for GAP_CYCLES clocks.
module uart_tx_arbiter #(
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  grant,
   output logic        tx_en,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        tx_done,
   output logic [1:0]  owner,
   output logic        active,
   output logic        err,
   output logic [15:0] sent_count
);

   localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGap} state_e;

   state_e          state_q, state_d;
   logic [3:0]      grant_q, grant_d;
   logic            tx_en_q, tx_en_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [1:0]      owner_q, owner_d;
   logic [1:0]      last_q, last_d;
   logic            active_q, active_d;
   logic            err_q, err_d;
   logic [15:0]     sent_q, sent_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

   logic [1:0] idx;
   logic [1:0] win;
   logic       win_found;
   logic       complete;

   always_comb begin
      // Scan upward from the requester after the last winner, wrapping.
      idx       = '0;
      win       = '0;
      win_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!win_found && req[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end

      state_d   = state_q;
      grant_d   = '0;
      tx_en_d   = 1'b0;
      err_d     = 1'b0;
      tx_data_d = tx_data_q;
      owner_d   = owner_q;
      last_d    = last_q;
      sent_d    = sent_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      complete  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               grant_d   = 4'b0001 << win;
               tx_en_d   = 1'b1;
               tx_data_d = req_data[{win, 3'b000} +: 8];
               owner_d   = win;
               last_d    = win;
               to_cnt_d  = '0;
               state_d   = StWaitBusy;
            end
         end
         StWaitBusy: begin
            if (tx_done) begin
               complete = 1'b1;
            end else if (tx_busy) begin
               state_d = StWaitDone;
            end else if (to_cnt_q == ToLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         StWaitDone: begin
            if (tx_done) complete = 1'b1;
         end
         StGap: begin
            if (gap_cnt_q == GapLast) state_d = StIdle;
            else gap_cnt_d = gap_cnt_q + GapW'(1);
         end
         default: state_d = StIdle;
      endcase

      if (complete) begin
         sent_d    = sent_q + 16'd1;
         gap_cnt_d = '0;
         state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
      end

      active_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         grant_q   <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= '0;
         owner_q   <= '0;
         last_q    <= 2'd3;
         active_q  <= 1'b0;
         err_q     <= 1'b0;
         sent_q    <= '0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         active_q  <= active_d;
         err_q     <= err_d;
         sent_q    <= sent_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign grant      = grant_q;
   assign tx_en      = tx_en_q;
   assign tx_data    = tx_data_q;
   assign owner      = owner_q;
   assign active     = active_q;
   assign err        = err_q;
   assign sent_count = sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin / completion-count model.
module tb_uart_tx_arbiter;

   localparam int unsigned GAP = 16;
   localparam int unsigned TO  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, tx_busy, tx_done;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic        tx_en, active, err;
   logic [7:0]  tx_data;
   logic [1:0]  owner;
   logic [15:0] sent_count;

   logic        reset_z, tx_busy_z, tx_done_z;
   logic [3:0]  req_z;
   logic [31:0] req_data_z;
   logic [3:0]  grant_z;
   logic        tx_en_z, active_z, err_z;
   logic [7:0]  tx_data_z;
   logic [1:0]  owner_z;
   logic [15:0] sent_count_z;

   int checks = 0;
   int errors = 0;
   int model_last;
   int model_sent;

   uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
      .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .owner(owner), .active(active), .err(err), .sent_count(sent_count)
   );

   uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT(8)) dut_z (
      .clk(clk), .reset(reset_z), .req(req_z), .req_data(req_data_z), .grant(grant_z),
      .tx_en(tx_en_z), .tx_data(tx_data_z), .tx_busy(tx_busy_z), .tx_done(tx_done_z),
      .owner(owner_z), .active(active_z), .err(err_z), .sent_count(sent_count_z)
   );

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int rr_pick(input logic [3:0] r, input int last);
      int w;
      w = -1;
      for (int k = 1; k <= 4; k++) if (w < 0 && r[(last + k) % 4]) w = (last + k) % 4;
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; tx_busy = 1'b0; tx_done = 1'b0;
      tick();
      reset = 1'b0;
      model_last = 3;
      model_sent = 0;
   endtask

   // Plays one uart_tx frame after a launch; reports any stray pulses and instability.
   task automatic drive_frame(input int d, input int len, input bit skip_busy, input bit scramble,
                              output int pulses, output int inact, output int moved);
      logic [7:0] d0;
      logic [1:0] o0;
      d0 = tx_data; o0 = owner; pulses = 0; inact = 0; moved = 0;
      for (int i = 0; i <= d + len; i++) begin
         if (scramble) begin req = 4'($urandom); req_data = $urandom; end
         tx_busy = !skip_busy && (i >= d);
         tx_done = (i == d + len);
         tick();
         pulses += $countones(grant) + int'(tx_en) + int'(err);
         inact  += int'(!active);
         moved  += int'(tx_data !== d0 || owner !== o0);
      end
      tx_busy = 1'b0; tx_done = 1'b0;
   endtask

   // Runs the hold-off period; fall is the clock (1-based) on which active dropped, 0 if never.
   task automatic drive_gap(input bit scramble, output int fall, output int pulses);
      fall = 0; pulses = 0;
      for (int k = 1; k <= int'(GAP) + 8; k++) begin
         if (scramble) begin
            req = 4'($urandom); req_data = $urandom;
            tx_done = 1'($urandom); tx_busy = 1'($urandom);
         end
         tick();
         pulses += $countones(grant) + int'(tx_en) + int'(err);
         if (!active) begin fall = k; break; end
      end
      tx_done = 1'b0; tx_busy = 1'b0;
      if (scramble) req = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'hF; req_data = $urandom; tx_busy = 1'b1; tx_done = 1'b1;
      tick(); tick();
      checks++;
      if ({grant, tx_en, tx_data, owner, active, err, sent_count} !== '0) begin
         errors++;
         $display("FAIL reset_values: got %h required 0",
                  {grant, tx_en, tx_data, owner, active, err, sent_count});
      end
      do_reset();
   endtask

   task automatic test_single();
      int p, ia, mv, fall, gp;
      do_reset();
      req = 4'b0001; req_data = {$urandom_range(0, 32'hFFFFFF), 8'h61};
      tick();
      checks++;
      if ({grant, tx_en} !== {4'b0001, 1'b1}) begin
         errors++; $display("FAIL single_grant: got %b/%b required 0001/1", grant, tx_en);
      end
      checks++;
      if ({tx_data, owner} !== {8'h61, 2'd0}) begin
         errors++; $display("FAIL single_data: got %h/%0d required 61/0", tx_data, owner);
      end
      model_last = 0;
      drive_frame(2, 5, 1'b0, 1'b1, p, ia, mv);
      model_sent++;
      checks++;
      if (p != 0 || ia != 0 || mv != 0) begin
         errors++; $display("FAIL single_frame: pulses %0d inactive %0d moved %0d required 0", p, ia, mv);
      end
      checks++;
      if (sent_count !== 16'd1) begin
         errors++; $display("FAIL single_count: got %0d required 1", sent_count);
      end
      drive_gap(1'b1, fall, gp);
      checks++;
      if (fall != int'(GAP) || gp != 0 || sent_count !== 16'd1) begin
         errors++;
         $display("FAIL single_gap: fall %0d pulses %0d count %0d required %0d/0/1", fall, gp,
                  sent_count, GAP);
      end
   endtask

   task automatic test_round_robin();
      int p, ia, mv, fall, gp, bad;
      int exp_w [5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'hF; req_data = 32'h64636261; bad = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         checks++;
         if (grant !== 4'(1 << exp_w[n]) || tx_data !== 8'(8'h61 + exp_w[n]) || !tx_en) begin
            errors++;
            $display("FAIL rr_grant%0d: got %b/%h required %b/%h", n, grant, tx_data,
                     4'(1 << exp_w[n]), 8'(8'h61 + exp_w[n]));
         end
         drive_frame(0, 1, 1'b0, 1'b0, p, ia, mv);
         drive_gap(1'b0, fall, gp);
         bad += p + ia + mv + gp + int'(fall != int'(GAP));
      end
      model_last = 0;
      model_sent = 5;
      req = '0;
      checks++;
      if (sent_count !== 16'd5 || bad != 0) begin
         errors++; $display("FAIL rr_count: got %0d anomalies %0d required 5/0", sent_count, bad);
      end
   endtask

   task automatic test_wrap();
      int p, ia, mv, fall, gp;
      do_reset();
      req = 4'b0010; req_data = $urandom;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++; $display("FAIL wrap_first: got %b required 0010", grant);
      end
      drive_frame(1, 2, 1'b0, 1'b1, p, ia, mv);
      drive_gap(1'b1, fall, gp);
      req = 4'b0011; req_data = $urandom;
      tick();
      checks++;
      if (grant !== 4'b0001 || owner !== 2'd0) begin
         errors++; $display("FAIL wrap_second: got %b/%0d required 0001/0", grant, owner);
      end
      drive_frame(0, 2, 1'b0, 1'b1, p, ia, mv);
      drive_gap(1'b1, fall, gp);
      model_last = 0;
      model_sent = 2;
   endtask

   task automatic test_timeout();
      int w, err_at, errs, p, ia, mv, fall, gp;
      logic [15:0] cnt0;
      cnt0 = sent_count;
      req = 4'($urandom_range(1, 15)); req_data = $urandom;
      w = rr_pick(req, model_last); model_last = w;
      tick();
      checks++;
      if (grant !== 4'(1 << w) || !tx_en) begin
         errors++; $display("FAIL to_launch: got %b required %b", grant, 4'(1 << w));
      end
      err_at = 0; errs = 0;
      for (int k = 1; k <= int'(TO); k++) begin
         req = 4'($urandom); tx_busy = 1'b0; tx_done = 1'b0;
         tick();
         if (err && err_at == 0) err_at = k;
         errs += int'(err) + $countones(grant) + int'(tx_en);
      end
      checks++;
      if (err_at != int'(TO) || errs != 1) begin
         errors++; $display("FAIL to_err: err at %0d pulses %0d required %0d/1", err_at, errs, TO);
      end
      checks++;
      if (active !== 1'b0 || sent_count !== cnt0) begin
         errors++;
         $display("FAIL to_state: active %b count %0d required 0/%0d", active, sent_count, cnt0);
      end
      req = '0;
      tick();
      checks++;
      if ({err, tx_en, active} !== 3'b000) begin
         errors++; $display("FAIL to_clear: got %b required 000", {err, tx_en, active});
      end
      req = 4'($urandom_range(1, 15)); req_data = $urandom;
      w = rr_pick(req, model_last); model_last = w;
      tick();
      checks++;
      if (grant !== 4'(1 << w) || tx_data !== req_data[8*w +: 8]) begin
         errors++; $display("FAIL to_next: got %b/%h required %b/%h", grant, tx_data,
                            4'(1 << w), req_data[8*w +: 8]);
      end
      drive_frame(0, 3, 1'b0, 1'b1, p, ia, mv);
      model_sent++;
      drive_gap(1'b1, fall, gp);
   endtask

   task automatic test_reset_mid();
      int pulses;
      req = 4'($urandom_range(1, 15)); req_data = $urandom;
      tick();
      req = '0; tx_busy = 1'b1;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({grant, tx_en, tx_data, owner, active, err, sent_count} !== '0) begin
         errors++;
         $display("FAIL midreset_values: got %h required 0",
                  {grant, tx_en, tx_data, owner, active, err, sent_count});
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0; tx_busy = 1'b0; pulses = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         pulses += $countones(grant) + int'(tx_en) + int'(active);
      end
      checks++;
      if (sent_count !== 16'd0 || pulses != 0) begin
         errors++;
         $display("FAIL midreset_ignore: count %0d activity %0d required 0/0", sent_count, pulses);
      end
      model_last = 3;
      model_sent = 0;
   endtask

   task automatic test_random();
      int w, p, ia, mv, fall, gp, err_at, idle_bad;
      logic [7:0] exp_d;
      for (int it = 0; it < 30; it++) begin
         idle_bad = 0;
         for (int k = 0; k < $urandom_range(0, 2); k++) begin
            req = '0; tx_done = 1'($urandom); tx_busy = 1'($urandom);
            tick();
            idle_bad += $countones(grant) + int'(tx_en) + int'(active);
         end
         tx_done = 1'b0; tx_busy = 1'b0;
         req = 4'($urandom_range(1, 15)); req_data = $urandom;
         w = rr_pick(req, model_last); model_last = w; exp_d = req_data[8*w +: 8];
         tick();
         checks++;
         if (idle_bad != 0 || grant !== 4'(1 << w) || !tx_en || tx_data !== exp_d ||
             owner !== 2'(w)) begin
            errors++;
            $display("FAIL rand_grant%0d: got %b/%h/%0d required %b/%h/%0d idle %0d", it, grant,
                     tx_data, owner, 4'(1 << w), exp_d, w, idle_bad);
         end
         if ($urandom_range(0, 7) == 0) begin
            err_at = 0;
            for (int k = 1; k <= int'(TO); k++) begin
               req = 4'($urandom);
               tick();
               if (err && err_at == 0) err_at = k;
            end
            req = '0;
            checks++;
            if (err_at != int'(TO) || active || sent_count !== 16'(model_sent)) begin
               errors++;
               $display("FAIL rand_timeout%0d: err at %0d active %b count %0d required %0d/0/%0d",
                        it, err_at, active, sent_count, TO, model_sent);
            end
         end else begin
            drive_frame($urandom_range(0, 3), $urandom_range(1, 6), ($urandom_range(0, 3) == 0),
                        1'b1, p, ia, mv);
            model_sent++;
            drive_gap(1'b1, fall, gp);
            checks++;
            if (p + ia + mv + gp != 0 || fall != int'(GAP) || sent_count !== 16'(model_sent)) begin
               errors++;
               $display("FAIL rand_frame%0d: anomalies %0d fall %0d count %0d required 0/%0d/%0d",
                        it, p + ia + mv + gp, fall, sent_count, GAP, model_sent);
            end
         end
      end
   endtask

   task automatic test_zero_gap();
      int w, last_z;
      reset_z = 1'b1; req_z = '0; tx_done_z = 1'b0; tx_busy_z = 1'b0;
      tick();
      reset_z = 1'b0; last_z = 3;
      for (int g = 0; g < 8; g++) begin
         req_z = 4'($urandom_range(1, 15)); req_data_z = $urandom;
         w = rr_pick(req_z, last_z); last_z = w;
         tick();
         checks++;
         if (grant_z !== 4'(1 << w) || !tx_en_z || tx_data_z !== req_data_z[8*w +: 8]) begin
            errors++;
            $display("FAIL zgap_grant%0d: got %b/%h required %b/%h", g, grant_z, tx_data_z,
                     4'(1 << w), req_data_z[8*w +: 8]);
         end
         tx_done_z = 1'b1;
         tick();
         tx_done_z = 1'b0;
         checks++;
         if (sent_count_z !== 16'(g + 1) || active_z || tx_en_z) begin
            errors++;
            $display("FAIL zgap_done%0d: count %0d active %b tx_en %b required %0d/0/0", g,
                     sent_count_z, active_z, tx_en_z, g + 1);
         end
      end
      req_z = '0;
   endtask

   initial begin
      reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
      reset_z = 1'b1; req_z = '0; req_data_z = '0; tx_busy_z = 1'b0; tx_done_z = 1'b0;
      model_last = 3; model_sent = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_random();
      test_zero_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
